div_reconstruct: RTL
====================

# div_reconstruct

Sequential radix-8 shift-add unit that rebuilds a signed dividend from a signed quotient, divisor and remainder: `dividend = q*d + r`. It is the inverse counterpart of the division datapath. It sits beside the divider as a self-check and as the multiply path for the same operand formats. It produces the 32-bit dividend in 6 clocks, with an overflow flag, under a start/busy/done handshake.

## Interface

Parameters:
- QW, 11: quotient width, signed two's complement.
- DW, 33: divisor and remainder width, signed two's complement.
- OW, 32: dividend output width, signed.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- q  in  QW  signed quotient.
- d  in  DW  signed divisor.
- r  in  DW  signed remainder.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result valid.
- dividend  out  OW  signed result, low OW bits of q*d+r.
- ovf  out  1  exact result outside [-2^(OW-1), 2^(OW-1)-1].

## Operation

- States: IDLE, MUL, FIX, DONE.
- IDLE:
  - When start=1, register the following:
    - |q| zero-extended to 12 bits (4 radix-8 digits).
    - |d| as 33 bits unsigned.
    - r.
    - neg = q[QW-1] ^ d[DW-1].
  - Clear the 45-bit accumulator acc, set cnt=3, then go to MUL.
- MUL, one digit per clock, MSB digit first:
  - acc <= (acc<<3) + digit[cnt]*|d|.
  - digit*|d| is formed from shifted adds of |d|, 2|d| and 4|d|; there is no multiplier primitive.
  - cnt decrements. After the cnt=0 step, go to FIX.
- FIX:
  - Compute p = neg ? -acc : acc in 46-bit signed, then s = p + sign-extended r.
  - Register dividend <= s[OW-1:0].
  - Register ovf <= (s != sign-extend of s[OW-1:0]).
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Magnitudes: |q| is at most 1024 (q = -1024 is legal). |d| is at most 2^32, held unsigned in 33 bits so d = -2^32 is exact. The maximum |q*d| is 2^42, so 45-bit acc never wraps.
- Zero handling: q=0 or d=0 gives p=0, so dividend=r and ovf reflects r only.
- start while busy is ignored. Operand inputs are don't-care after the IDLE capture edge.
- dividend and ovf hold their last value until the next FIX.

## Timing

- Reset values: busy=0, done=0, dividend=0, ovf=0, state=IDLE, acc=0, cnt=0.
- E0 = edge sampling start=1 in IDLE. The MUL steps are at E1..E4, FIX at E5.
- done=1 and dividend/ovf valid during the cycle after E5. done drops and state returns to IDLE at E6.
- busy=1 from after E0 through the DONE cycle.
- Fixed latency: 6 clocks from the start sample to done. Throughput is one operation per 7 clocks.
  - start held high through DONE is sampled again in the cycle after DONE (IDLE), not in DONE itself.
- Reset asserted mid-operation:
  - All state returns to reset values immediately (asynchronous).
  - No done pulse is produced.
  - The next start after reset release behaves normally.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure

- Shared package `div_pkg` holds:
  - QW, DW, OW, RADIX_BITS=3 and NDIG=4.
  - The state enum {IDLE, MUL, FIX, DONE}.
  - ACC_W=45.
- The package is shared with the divider so both ends use the same widths.
- One sub-module, `div_digit_mul`: combinational, maps a 3-bit digit and 33-bit |d| to a 36-bit digit*|d|.
- FSM, counter, accumulator and FIX logic live in `div_reconstruct`.

## Test plan

- q=5, d=7, r=3 → done 6 clocks after start, dividend=38, ovf=0. busy high for the 6 cycles before done falls.
- q=-5, d=7, r=-3 → dividend=-38. Also q=5, d=-7, r=-3 → -38, and q=-5, d=-7, r=3 → 38.
- q=1023, d=4194304, r=0 → ovf=1, dividend=-4194304 (low 32 bits of 4290772992).
- q=-1024, d=2097152, r=-1 → dividend=-2147483648-1 wraps to 2147483647 with ovf=1. With r=0 → -2147483648, ovf=0.
- q=0, d=123456, r=-77 → dividend=-77, ovf=0.
- Mid-operation behaviour:
  - Start a job, pulse start again during MUL → ignored, single done.
  - Assert rst at E3 → busy=0, done never pulses, dividend=0.
  - Then q=2, d=3, r=1 → 7.

Source files
------------

// File: rtl/div_pkg.sv
// Widths, digit geometry and FSM encoding shared by the divider and the
// reconstruct/multiply path so both ends agree on operand formats.
package div_pkg;

  localparam int QW         = 11;
  localparam int DW         = 33;
  localparam int OW         = 32;
  localparam int RADIX_BITS = 3;
  localparam int NDIG       = 4;
  localparam int QMAG_W     = RADIX_BITS * NDIG;
  localparam int ACC_W      = 45;
  localparam int CNT_W      = 2;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/div_digit_mul.sv
// Combinational radix-8 digit times magnitude, built only from shifted
// copies of the magnitude (x1, x2, x4) selected by the digit bits.
module div_digit_mul #(
  parameter int DW = div_pkg::DW
) (
  input  logic [div_pkg::RADIX_BITS-1:0]    digit,
  input  logic [DW-1:0]                     mag,
  output logic [DW+div_pkg::RADIX_BITS-1:0] prod
);
  import div_pkg::*;

  localparam int PW = DW + RADIX_BITS;

  logic [PW-1:0] part [RADIX_BITS];

  generate
    for (genvar gi = 0; gi < RADIX_BITS; gi++) begin : g_part
      assign part[gi] = digit[gi] ? (PW'(mag) << gi) : '0;
    end
  endgenerate

  always_comb begin
    prod = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      prod = prod + part[i];
    end
  end

endmodule

// File: rtl/div_reconstruct.sv
// Rebuilds dividend = q*d + r with a 4-step radix-8 shift-add over |q|,
// then applies the product sign and remainder and flags out-of-range results.
module div_reconstruct #(
  parameter int QW = div_pkg::QW,
  parameter int DW = div_pkg::DW,
  parameter int OW = div_pkg::OW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [QW-1:0] q,
  input  logic [DW-1:0] d,
  input  logic [DW-1:0] r,
  output logic          busy,
  output logic          done,
  output logic [OW-1:0] dividend,
  output logic          ovf
);
  import div_pkg::*;

  localparam int PROD_W = DW + RADIX_BITS;
  localparam int SUM_W  = ACC_W + 1;

  state_t              state_reg, state_next;
  logic [QMAG_W-1:0]   qmag_reg, qmag_next;
  logic [DW-1:0]       dmag_reg, dmag_next;
  logic [DW-1:0]       r_reg, r_next;
  logic                neg_reg, neg_next;
  logic [ACC_W-1:0]    acc_reg, acc_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic [OW-1:0]       dividend_reg, dividend_next;
  logic                ovf_reg, ovf_next;

  // Operand magnitudes; q is widened first so that -1024 negates exactly.
  logic [QMAG_W-1:0]   q_ext, q_mag;
  logic [DW-1:0]       d_mag;

  assign q_ext = {{(QMAG_W-QW){q[QW-1]}}, q};
  assign q_mag = q_ext[QMAG_W-1] ? -q_ext : q_ext;
  assign d_mag = d[DW-1] ? -d : d;

  logic [RADIX_BITS-1:0] digits [NDIG];
  logic [RADIX_BITS-1:0] digit;
  logic [PROD_W-1:0]     prod;
  logic [ACC_W-1:0]      acc_shift;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      assign digits[gi] = qmag_reg[gi*RADIX_BITS +: RADIX_BITS];
    end
  endgenerate

  assign digit     = digits[cnt_reg];
  assign acc_shift = {acc_reg[ACC_W-RADIX_BITS-1:0], {RADIX_BITS{1'b0}}};

  div_digit_mul #(
    .DW (DW)
  ) u_digit_mul (
    .digit (digit),
    .mag   (dmag_reg),
    .prod  (prod)
  );

  // Sign fix-up and remainder add, one bit wider than acc so -acc is exact.
  logic [SUM_W-1:0] acc_ext, prod_signed, r_ext, sum, sum_lo_ext;

  assign acc_ext     = {1'b0, acc_reg};
  assign prod_signed = neg_reg ? -acc_ext : acc_ext;
  assign r_ext       = {{(SUM_W-DW){r_reg[DW-1]}}, r_reg};
  assign sum         = prod_signed + r_ext;
  assign sum_lo_ext  = {{(SUM_W-OW){sum[OW-1]}}, sum[OW-1:0]};

  always_comb begin
    state_next    = state_reg;
    qmag_next     = qmag_reg;
    dmag_next     = dmag_reg;
    r_next        = r_reg;
    neg_next      = neg_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    dividend_next = dividend_reg;
    ovf_next      = ovf_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          qmag_next  = q_mag;
          dmag_next  = d_mag;
          r_next     = r;
          neg_next   = q[QW-1] ^ d[DW-1];
          acc_next   = '0;
          cnt_next   = CNT_W'(NDIG - 1);
          state_next = MUL;
        end
      end
      MUL: begin
        acc_next = acc_shift + ACC_W'(prod);
        if (cnt_reg == '0) begin
          state_next = FIX;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      FIX: begin
        dividend_next = sum[OW-1:0];
        ovf_next      = (sum != sum_lo_ext);
        state_next    = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qmag_reg     <= '0;
      dmag_reg     <= '0;
      r_reg        <= '0;
      neg_reg      <= 1'b0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      dividend_reg <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      qmag_reg     <= qmag_next;
      dmag_reg     <= dmag_next;
      r_reg        <= r_next;
      neg_reg      <= neg_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      dividend_reg <= dividend_next;
      ovf_reg      <= ovf_next;
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign dividend = dividend_reg;
  assign ovf      = ovf_reg;

endmodule
